route_enable_gen: RTL
=====================

# route_enable_gen

Source-routed input-port front end for one router input of the MouseTrap NoC. It accepts flits from the upstream link, decodes the 2-bit output-port selector in each head flit, and consumes that selector by shifting the route field. It drives the one-hot packet-enable and tail-passed strobes that the per-output request generators consume, and forwards flits through a one-deep output register toward the crossbar. Illegal U-turn packets are discarded and counted.

## Interface
Parameters:
- LOCATION, 0, index of this input port (0..3); an output selector equal to LOCATION is an illegal U-turn
- OUTPORTS, 4, number of router output ports (fixed at 4; the selector is 2 bits)
- FLIT_W, 34, flit width: [FLIT_W-1:FLIT_W-2] type, [FLIT_W-3:0] payload
- ROUTE_W, 16, width of the head-flit route field at payload [ROUTE_W-1:0]; must be even and ≥2

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- flit_i  in  FLIT_W  upstream flit
- valid_i  in  1  upstream flit valid
- ready_o  out  1  this block accepts flit_i on the rising edge where valid_i && ready_o
- flit_o  out  FLIT_W  registered flit toward the crossbar
- valid_o  out  1  flit_o valid
- ready_i  in  1  downstream accepts flit_o on the rising edge where valid_o && ready_i
- packet_enable_o  out  OUTPORTS  one-hot enable of the selected output; feeds PacketEnable_up_i of that output's request generator
- tailpassed_o  out  1  one-cycle strobe when a tail has left the output register; feeds Tailpassed_dw_i
- drop_cnt_o  out  8  saturating count of discarded packets and stray flits
- busy_o  out  1  high in FWD or DROP

## Operation
- Flit types: 2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single (head and tail).
- Port selector p = payload[1:0] of a head or single flit.
- Forwarded head: route field replaced by {2'b00, route[ROUTE_W-1:2]}. All other bits pass unmodified.
- ready_o = (!valid_o || ready_i) in FWD and DROP. In IDLE, ready_o additionally requires packet_enable_o == 0 and valid_o == 0.
- State IDLE:
  - Head accepted, p != LOCATION: load output register, set packet_enable_o = 1<<p, go to FWD.
  - Single accepted, p != LOCATION: same load and enable, stay IDLE.
  - Head accepted, p == LOCATION: discard, drop_cnt +1, go to DROP.
  - Single accepted, p == LOCATION: discard, drop_cnt +1, stay IDLE.
  - Body or tail accepted: stray flit; discard, drop_cnt +1.
- State FWD:
  - Every accepted flit is loaded into the output register.
  - A tail accepted: go to IDLE.
  - A head accepted: protocol error; forward unmodified as a body flit and do not re-decode.
- State DROP:
  - Accepted flits are discarded; ready_o is constant 1.
  - Tail or single accepted: go to IDLE. No extra count.
- Enable release: on the cycle after the output handshake of a tail or single flit, packet_enable_o goes to 0 and tailpassed_o is 1 for exactly one cycle.
- drop_cnt_o saturates at 255 and never wraps.
- Reset mid-packet: state goes to IDLE, the output register empties, enables clear, and the in-flight packet is lost (no count).

## Timing
- Reset values: valid_o=0, flit_o=0, packet_enable_o=0, tailpassed_o=0, drop_cnt_o=0, busy_o=0, state IDLE.
- Latency: a flit accepted at edge k appears on flit_o/valid_o after edge k. packet_enable_o rises after the same edge as the head's valid_o.
- Throughput: 1 flit/cycle in FWD with ready_i held high. Any ready_i stall holds flit_o and valid_o stable.
- Tail output handshake at edge T:
  - After T: packet_enable_o=0, tailpassed_o=1, ready_o=1 (IDLE).
  - Next head accepted at edge T+1 earliest; its enable is visible after T+1.
- Simultaneous output handshake and new load in FWD: the register is replaced and valid_o stays 1.
- packet_enable_o is never multi-hot and never changes while valid_o=1 for a packet flit.

## Test plan
- Reset then idle: all outputs 0, ready_o=1.
- Head (p=2, route 0x00B6) → body → tail, LOCATION=0, ready_i=1:
  - flit_o route becomes 0x002D.
  - packet_enable_o=4'b0100 for 3 cycles, then 0 with tailpassed_o pulsed once.
- U-turn head p=0 with LOCATION=0, then 2 bodies and a tail:
  - No valid_o.
  - drop_cnt_o=1; busy_o=1 until the tail, then IDLE.
- Single flit p=1 while ready_i=0 for 3 cycles:
  - flit_o held stable; enable=4'b0010 throughout.
  - tailpassed_o pulses the cycle after ready_i rises.
- Back-to-back packets: the second head stalls until the cycle after the first tail handshake; enable switches with no overlap.
- 300 stray body flits in IDLE: drop_cnt_o saturates at 255. Then assert rstn_i=0 mid-packet: all outputs clear asynchronously.

Source files
------------

// File: rtl/route_enable_gen.sv
// Input-port front end of a source-routed NoC router: decodes the 2-bit selector
// of each head flit, shifts it out of the route field and drives one-hot output enables.
module route_enable_gen #(
  parameter int LOCATION = 0,
  parameter int OUTPORTS = 4,
  parameter int FLIT_W   = 34,
  parameter int ROUTE_W  = 16
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [FLIT_W-1:0]   flit_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [FLIT_W-1:0]   flit_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [OUTPORTS-1:0] packet_enable_o,
  output logic                tailpassed_o,
  output logic [7:0]          drop_cnt_o,
  output logic                busy_o,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [1:0] T_HEAD   = 2'b10;
  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_SINGLE = 2'b11;
  localparam logic [1:0] LOC      = 2'(LOCATION);

  state_t                state_q, state_d;
  logic [FLIT_W-1:0]     flit_q;
  logic                  valid_q;
  logic [OUTPORTS-1:0]   pe_q;
  logic                  tp_q;
  logic [7:0]            cnt_q;

  logic [1:0]            in_type, out_type, sel;
  logic                  accept, out_hs, tail_out;
  logic                  load, set_pe, count_drop;
  logic [FLIT_W-1:0]     load_flit, head_flit;
  logic [OUTPORTS-1:0]   sel_onehot;

  // Handshake: a flit moves on a rising edge where its valid and the receiver's
  // ready are both high; valid never depends on ready, and a stalled flit is held.
  assign in_type  = flit_i[FLIT_W-1:FLIT_W-2];
  assign out_type = flit_q[FLIT_W-1:FLIT_W-2];
  assign sel      = flit_i[1:0];
  assign out_hs   = valid_q && ready_i;
  assign tail_out = out_hs && ((out_type == T_TAIL) || (out_type == T_SINGLE));

  always_comb begin
    head_flit = flit_i;
    head_flit[ROUTE_W-1:0] = {2'b00, flit_i[ROUTE_W-1:2]};
  end

  always_comb begin
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  end

  // IDLE waits for the previous packet's enable to be released before a new head.
  always_comb begin
    if (state_q == IDLE) ready_o = !valid_q && (pe_q == '0);
    else                 ready_o = !valid_q || ready_i;
  end

  assign accept = valid_i && ready_o;

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    load_flit  = flit_i;
    set_pe     = 1'b0;
    count_drop = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if ((in_type == T_HEAD) || (in_type == T_SINGLE)) begin
            if (sel == LOC) begin
              count_drop = 1'b1;
              if (in_type == T_HEAD) state_d = DROP;
            end else begin
              load      = 1'b1;
              load_flit = head_flit;
              set_pe    = 1'b1;
              if (in_type == T_HEAD) state_d = FWD;
            end
          end else begin
            count_drop = 1'b1;
          end
        end
      end
      FWD: begin
        if (accept) begin
          load = 1'b1;
          case (in_type)
            T_HEAD:   load_flit[FLIT_W-1:FLIT_W-2] = T_BODY;
            T_TAIL:   state_d = IDLE;
            T_SINGLE: begin
              load_flit[FLIT_W-1:FLIT_W-2] = T_TAIL;
              state_d = IDLE;
            end
            default: ;
          endcase
        end
      end
      DROP: begin
        if (accept && ((in_type == T_TAIL) || (in_type == T_SINGLE))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      flit_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= '0;
      tp_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tp_q    <= tail_out;
      if (load)        valid_q <= 1'b1;
      else if (out_hs) valid_q <= 1'b0;
      if (load) flit_q <= load_flit;
      if (set_pe)        pe_q <= sel_onehot;
      else if (tail_out) pe_q <= '0;
      if (count_drop && (cnt_q != 8'hFF)) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign flit_o          = flit_q;
  assign valid_o         = valid_q;
  assign packet_enable_o = pe_q;
  assign tailpassed_o    = tp_q;
  assign drop_cnt_o      = cnt_q;
  assign busy_o          = (state_q != IDLE);
  assign state_o         = state_q;

endmodule
